// File: rtl/ascii_field_pkg.sv
// ascii_field_pkg: shared constants, FSM states and power-of-ten helper for the field scheduler
package ascii_field_pkg;
  localparam int FIELD_LEN = 7;
  localparam int NUM_DIGITS = 5;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_ZERO = 7'h30;
  typedef enum logic [1:0] {IDLE, CONVERT, WRITE} state_t;
  function automatic logic [15:0] pow10(input logic [2:0] k);
    return k == 3'd0 ? 16'd1 : k == 3'd1 ? 16'd10 : k == 3'd2 ? 16'd100 : k == 3'd3 ? 16'd1000 : 16'd10000;
  endfunction
endpackage

// File: rtl/ascii_field_scheduler_div10.sv
// div10_step: combinational 16-bit divide by ten, one decimal digit per use
module div10_step (
  input  logic [15:0] din,
  output logic [15:0] quo,
  output logic [3:0]  rem
);
  assign quo = din / 16'd10;
  assign rem = 4'(din % 16'd10);
endmodule

// File: rtl/ascii_field_scheduler.sv
// ascii_field_scheduler: round-robin shared binary-to-ASCII converter writing 7-char fields to text RAM
module ascii_field_scheduler
  import ascii_field_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ADDR_W = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [16*N_REQ-1:0]     val_flat,
  input  logic [ADDR_W*N_REQ-1:0] base_flat,
  output logic [N_REQ-1:0]        grant,
  output logic                    busy,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [6:0]              wr_data,
  output logic                    done
);
  localparam int IW = N_REQ > 1 ? $clog2(N_REQ) : 1;
  state_t state;
  logic [2:0] cnt, nxt, k;
  logic [15:0] work, orig, quo, sel_val;
  logic [3:0] rem;
  logic [3:0] dig [NUM_DIGITS];
  logic [ADDR_W-1:0] base, sel_base;
  logic [IW-1:0] last, win;
  logic [6:0] ch;
  div10_step u_div (.din(work), .quo(quo), .rem(rem));
  // lowest rotation distance from last winner is checked last, so it wins
  always_comb begin
    win = last;
    sel_val = '0;
    sel_base = '0;
    for (int i = N_REQ; i >= 1; i--)
      if (req[IW'((int'(last) + i) % N_REQ)]) win = IW'((int'(last) + i) % N_REQ);
    for (int i = 0; i < N_REQ; i++)
      if (IW'(i) == win) begin
        sel_val = val_flat[16*i +: 16];
        sel_base = base_flat[ADDR_W*i +: ADDR_W];
      end
  end
  // offsets 1..5 carry digits 4..0, leading zeros above the ones digit are blanked
  always_comb begin
    nxt = cnt + 3'd1;
    k = (nxt >= 3'd1 && nxt <= 3'd5) ? 3'd5 - nxt : 3'd0;
    ch = (nxt >= 3'd1 && nxt <= 3'd5 && (k == 3'd0 || orig >= pow10(k))) ? ASCII_ZERO + {3'b0, dig[k]} : ASCII_SPACE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      work <= '0;
      orig <= '0;
      base <= '0;
      dig <= '{default: '0};
      last <= IW'(N_REQ - 1);
      grant <= '0;
      busy <= 1'b0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done <= 1'b0;
    end else begin
      grant <= '0;
      done <= 1'b0;
      if (state == IDLE) begin
        if (|req) begin
          grant <= N_REQ'(1) << win;
          busy <= 1'b1;
          work <= sel_val;
          orig <= sel_val;
          base <= sel_base;
          last <= win;
          cnt <= '0;
          state <= CONVERT;
        end
      end else if (state == CONVERT) begin
        dig[cnt] <= rem;
        work <= quo;
        cnt <= nxt;
        if (cnt == 3'(NUM_DIGITS - 1)) begin
          state <= WRITE;
          cnt <= '0;
          wr_en <= 1'b1;
          wr_addr <= base;
          wr_data <= ASCII_SPACE;
        end
      end else if (cnt == 3'(FIELD_LEN - 1)) begin
        state <= IDLE;
        wr_en <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        cnt <= nxt;
        wr_addr <= base + ADDR_W'(nxt);
        wr_data <= ch;
      end
    end
  end
endmodule

// File: tb/tb_ascii_field_scheduler.sv
// tb_ascii_field_scheduler: directed vectors with hand-written expected fields
module tb_ascii_field_scheduler;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [3:0] req = '0;
  logic [63:0] val_flat = '0;
  logic [43:0] base_flat = '0;
  logic [3:0] grant;
  logic busy, wr_en, done;
  logic [10:0] wr_addr;
  logic [6:0] wr_data;
  int total = 0;
  int bad = 0;
  ascii_field_scheduler #(.N_REQ(4), .ADDR_W(11)) dut (
    .clk(clk), .reset(reset), .req(req), .val_flat(val_flat), .base_flat(base_flat),
    .grant(grant), .busy(busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .done(done)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic set_src(input int i, input logic [15:0] v, input logic [10:0] b);
    val_flat[16*i +: 16] = v;
    base_flat[11*i +: 11] = b;
  endtask
  task automatic field(input logic [3:0] r, input logic [3:0] g, input logic [10:0] b, input string s, input bit keep, input bit tog);
    req = r;
    @(negedge clk);
    check("grant", grant, g);
    check("busy_c0", busy, 1);
    if (!keep) req = '0;
    for (int c = 1; c <= 4; c++) begin
      if (tog) req[2] = ~req[2];
      @(negedge clk);
      check("cv_wr_en", wr_en, 0);
      check("cv_grant", grant, 0);
      check("cv_busy", busy, 1);
    end
    for (int o = 0; o < 7; o++) begin
      if (tog && o < 6) req[2] = ~req[2];
      @(negedge clk);
      check("wr_en", wr_en, 1);
      check("wr_addr", wr_addr, 11'(b + o));
      check("wr_data", wr_data, 7'(s[o]));
      check("wr_grant", grant, 0);
    end
    @(negedge clk);
    check("done", done, 1);
    check("busy_end", busy, 0);
    check("wr_en_end", wr_en, 0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_done", done, 0);
    reset = 1'b0;
    set_src(0, 16'd12345, 11'h100);
    field(4'b0001, 4'b0001, 11'h100, " 12345 ", 0, 0);
    set_src(0, 16'd0, 11'h100);
    field(4'b0001, 4'b0001, 11'h100, "     0 ", 0, 0);
    set_src(0, 16'd65535, 11'h200);
    field(4'b0001, 4'b0001, 11'h200, " 65535 ", 0, 0);
    set_src(0, 16'd10, 11'd2045);
    field(4'b0001, 4'b0001, 11'd2045, "    10 ", 0, 0);
    set_src(0, 16'd9, 11'h020);
    field(4'b0001, 4'b0001, 11'h020, "     9 ", 0, 1);
    @(negedge clk);
    check("no_stray_grant", grant, 0);
    check("no_stray_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    set_src(0, 16'd7, 11'h000);
    set_src(1, 16'd123, 11'h010);
    set_src(2, 16'd4000, 11'h020);
    set_src(3, 16'd50001, 11'h030);
    field(4'b1111, 4'b0001, 11'h000, "     7 ", 1, 0);
    field(4'b1111, 4'b0010, 11'h010, "   123 ", 1, 0);
    field(4'b1111, 4'b0100, 11'h020, "  4000 ", 1, 0);
    field(4'b1111, 4'b1000, 11'h030, " 50001 ", 1, 0);
    field(4'b1111, 4'b0001, 11'h000, "     7 ", 0, 0);
    set_src(0, 16'd12345, 11'h100);
    req = 4'b0001;
    @(negedge clk);
    check("mid_grant", grant, 4'b0001);
    req = '0;
    repeat (7) @(negedge clk);
    check("mid_wr_en", wr_en, 1);
    check("mid_wr_addr", wr_addr, 11'h102);
    check("mid_wr_data", wr_data, 7'h32);
    #1 reset = 1'b1;
    #1;
    check("async_wr_en", wr_en, 0);
    check("async_busy", busy, 0);
    check("async_grant", grant, 0);
    check("async_done", done, 0);
    check("async_wr_addr", wr_addr, 0);
    check("async_wr_data", wr_data, 0);
    @(negedge clk);
    reset = 1'b0;
    field(4'b0011, 4'b0001, 11'h100, " 12345 ", 0, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    field(4'b0010, 4'b0010, 11'h010, "   123 ", 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ascii_field_scheduler.md
# ascii_field_scheduler

Sequential scheduler that shares one binary-to-decimal-ASCII conversion path among several 16-bit counter sources and writes each result as a 7-character field into the VGA text buffer. A round-robin arbiter picks one requester, an iterative divide-by-10 loop produces one decimal digit per cycle, and a write sequencer streams the characters to the text-RAM write port. It sits between the timer/counter blocks and the character-buffer RAM feeding the VGA text renderer.

## Interface
- N_REQ, 4, number of requesters
- ADDR_W, 11, text-buffer address width
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- req  in  N_REQ  per-requester conversion request (level)
- val_flat  in  16*N_REQ  requester i value at bits [16*i+15:16*i]
- base_flat  in  ADDR_W*N_REQ  requester i field start address
- grant  out  N_REQ  one-hot, one-cycle pulse: request accepted, value captured
- busy  out  1  high from capture until last write
- wr_en  out  1  text-RAM write strobe
- wr_addr  out  ADDR_W  text-RAM address
- wr_data  out  7  ASCII character
- done  out  1  one-cycle pulse after field fully written

## Operation
- States: IDLE, CONVERT, WRITE.
- IDLE: if any req bit set, at the clock edge (capture edge E0): select winner round-robin starting at last_grant+1 modulo N_REQ; latch its value, base and index; grant<=onehot(winner); state->CONVERT.
- last_grant resets to N_REQ-1, so requester 0 wins first after reset.
- req is ignored outside IDLE; requester holds req and val stable until its grant pulse; keeping req high re-requests.
- CONVERT: 5 cycles. Each edge: remainder of working value /10 stored as digit k (k=0 ones .. 4 ten-thousands), working value <= quotient.
- Blanking: digit k is ASCII (0x30+d) if k==0 or original value >= 10^k, else space 0x20.
- Field layout, offset 0..6: space, digit4, digit3, digit2, digit1, digit0, space. Offset 0 is always space (16-bit max 65535).
- WRITE: 7 cycles, wr_en=1, wr_addr=base+offset (modulo 2^ADDR_W, wraps silently), wr_data=char[offset], offset 0 first.
- After offset 6: state->IDLE, done=1 for one cycle.
- Reset (any time, incl. mid-field): all outputs 0 immediately, state IDLE, last_grant=N_REQ-1; partially written field left as-is in RAM.

## Timing
- Cycle n = period following edge En.
- Cycle 0: grant pulse, busy=1. Cycles 0-4: CONVERT. Cycles 5-11: wr_en=1, offsets 0-6. Cycle 12: done=1, busy=0, state IDLE.
- Earliest next capture at E13; per-field period 13 cycles.
- All outputs registered; reset values: grant=0, busy=0, wr_en=0, wr_addr=0, wr_data=0, done=0.
- req changes during busy have no effect; simultaneous requests resolve strictly round-robin, no starvation (max wait (N_REQ-1)*13+13 cycles).

## Structure
- Package ascii_field_pkg: FIELD_LEN=7, NUM_DIGITS=5, ASCII_SPACE=7'h20, ASCII_ZERO=7'h30, state enum {IDLE, CONVERT, WRITE}.
- Sub-module div10_step: combinational 16-bit in -> quotient (16) and remainder (4); used once in CONVERT loop.
- Top holds arbiter, FSM, digit registers, write counter.

## Test plan
- req=0001, val0=12345, base0=0x100 -> grant=0001 cycle 0; writes 0x20,'1','2','3','4','5',0x20 to 0x100-0x106 in cycles 5-11; done cycle 12.
- val0=0 -> chars 0x20×5, '0', 0x20; val0=65535 -> 0x20,'6','5','5','3','5',0x20; val0=10 -> 0x20×4,'1','0',0x20.
- req=1111 held continuously -> grants 0001,0010,0100,1000,0001 at 13-cycle spacing.
- base=2^ADDR_W-3 -> addresses wrap to 0..3 after 2045..2047.
- Assert reset during cycle 7 (write offset 2) -> wr_en, busy, grant, done drop to 0 immediately; after release, req=0010 granted first to requester 1 only if req0 low, requester 0 wins if both high.
- Toggle req[2] high/low during busy -> no grant, no effect on current field.
